// File: rtl/div_share_pkg.sv
// Shared types and helpers for the divider-sharing arbiter slice.
// Latency: n/a (types, constants and a combinational helper function).
// Backpressure: n/a.
// Contents: FSM state enum, divide-by-zero quotient fill, round-robin pick function.
package div_share_pkg;

   localparam int MAX_NREQ = 8;
   localparam int MAX_IDW  = 3;

   // Quotient reported for divide-by-zero; users slice the low WIDTH bits.
   localparam logic [31:0] DIV_ZERO_Q = '1;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_CLR,
      WAIT_DONE,
      RESP
   } state_t;

   typedef struct packed {
      logic               found;
      logic [MAX_IDW-1:0] idx;
   } pick_t;

   // First set bit of req scanning ptr, ptr+1, ... modulo nreq.
   // Walks from the far end so the candidate closest to ptr is written last.
   function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                     input logic [MAX_IDW-1:0]  ptr,
                                     input int                  nreq);
      pick_t p;
      int    j;
      p = '0;
      for (int k = MAX_NREQ - 1; k >= 0; k--) begin
         if (k < nreq) begin
            j = int'(ptr) + k;
            if (j >= nreq) begin
               j = j - nreq;
            end
            if (req[j]) begin
               p.found = 1'b1;
               p.idx   = MAX_IDW'(j);
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/div_share_arbiter_if.sv
// Client and divider signal bundle for div_share_arbiter.
// Latency: n/a (wiring only).
// Backpressure: none; clients hold req until gnt, the divider signals via div_done.
// master: arbiter view (drives gnt/rsp_*/busy/div_a/div_b/div_init).
// slave: environment view (drives req/opa/opb and the divider results).
interface div_share_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 3
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] opa;
   logic [NREQ*WIDTH-1:0] opb;
   logic [NREQ-1:0]       gnt;
   logic                  rsp_valid;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_q;
   logic [WIDTH-1:0]      rsp_r;
   logic                  rsp_err;
   logic                  busy;
   logic [WIDTH-1:0]      div_a;
   logic [WIDTH-1:0]      div_b;
   logic                  div_init;
   logic                  div_done;
   logic [WIDTH-1:0]      div_q;
   logic [WIDTH-1:0]      div_r;

   modport master (
      input  req, opa, opb, div_done, div_q, div_r,
      output gnt, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err, busy,
             div_a, div_b, div_init
   );

   modport slave (
      output req, opa, opb, div_done, div_q, div_r,
      input  gnt, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err, busy,
             div_a, div_b, div_init
   );
endinterface

// File: rtl/rr_pick_nreq.sv
// Combinational round-robin priority picker: first set req bit at or after ptr.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: req (request vector), ptr (scan start) -> onehot, idx, any.
module rr_pick_nreq
   import div_share_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] onehot,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   pick_t pick;

   always_comb begin
      pick = rr_pick(MAX_NREQ'(req), MAX_IDW'(ptr), NREQ);
   end

   assign idx    = pick.idx[IDW-1:0];
   assign any    = pick.found;
   assign onehot = pick.found ? (NREQ'(1) << pick.idx) : '0;

endmodule

// File: rtl/div_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle divider among NREQ clients.
// Latency: gnt->rsp_valid = 4 cycles + divider compute; divide-by-zero answers in 1 cycle.
// Backpressure: one op in flight; busy high outside IDLE, req ignored until IDLE.
// Ports: clk, rst (sync, active-high), bus (div_share_arbiter_if.master): client
// req/opa/opb/gnt/rsp_*, busy, and divider div_a/div_b/div_init/div_done/div_q/div_r.
// Optional: define DIVARB_TIMEOUT_EN to add a TMO_CYCLES watchdog in WAIT_DONE.
module div_share_arbiter
   import div_share_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int WIDTH      = 3,
   parameter int TMO_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst,
   div_share_arbiter_if.master bus
);

   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   if (NREQ < 2 || NREQ > MAX_NREQ || WIDTH < 1 || TMO_CYCLES < 1) begin : g_bad_cfg
      $error("div_share_arbiter: unsupported NREQ/WIDTH/TMO_CYCLES");
   end

   state_t           state;
   logic [IDW-1:0]   rr_ptr;
   logic [IDW-1:0]   cur_id;

   logic [NREQ-1:0]  pick_oh;
   logic [IDW-1:0]   pick_idx;
   logic             pick_any;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;

`ifdef DIVARB_TIMEOUT_EN
   localparam int TW = $clog2(TMO_CYCLES + 1);
   logic [TW-1:0] tmo_cnt;
`endif

   rr_pick_nreq #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req    (bus.req),
      .ptr    (rr_ptr),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   assign sel_a = bus.opa[int'(pick_idx)*WIDTH +: WIDTH];
   assign sel_b = bus.opb[int'(pick_idx)*WIDTH +: WIDTH];

   // The grant must name the cycle in which operands are captured, so it is
   // decoded from the registered state rather than delayed by another flop.
   assign bus.gnt = (state == IDLE) ? pick_oh : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         cur_id        <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_id    <= '0;
         bus.rsp_q     <= '0;
         bus.rsp_r     <= '0;
         bus.rsp_err   <= 1'b0;
         bus.busy      <= 1'b0;
         bus.div_init  <= 1'b0;
         bus.div_a     <= '0;
         bus.div_b     <= '0;
`ifdef DIVARB_TIMEOUT_EN
         tmo_cnt       <= '0;
`endif
      end else begin
         bus.rsp_valid <= 1'b0;
         bus.div_init  <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  bus.div_a <= sel_a;
                  bus.div_b <= sel_b;
                  cur_id    <= pick_idx;
                  rr_ptr    <= (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                  bus.busy  <= 1'b1;
                  if (sel_b == '0) begin
                     // Divide-by-zero never touches the divider.
                     bus.rsp_valid <= 1'b1;
                     bus.rsp_id    <= pick_idx;
                     bus.rsp_q     <= DIV_ZERO_Q[WIDTH-1:0];
                     bus.rsp_r     <= sel_a;
                     bus.rsp_err   <= 1'b1;
                     state         <= RESP;
                  end else begin
                     bus.div_init <= 1'b1;
                     state        <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               state <= WAIT_CLR;
            end
            WAIT_CLR: begin
               // div_done may still be high from the previous operation here.
               state <= WAIT_DONE;
`ifdef DIVARB_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
            end
            WAIT_DONE: begin
               if (bus.div_done) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_id    <= cur_id;
                  bus.rsp_q     <= bus.div_q;
                  bus.rsp_r     <= bus.div_r;
                  bus.rsp_err   <= 1'b0;
                  state         <= RESP;
               end
`ifdef DIVARB_TIMEOUT_EN
               else if (tmo_cnt == TW'(TMO_CYCLES - 1)) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_id    <= cur_id;
                  bus.rsp_q     <= '0;
                  bus.rsp_r     <= '0;
                  bus.rsp_err   <= 1'b1;
                  state         <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            RESP: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule
